// File: rtl/mems_write_arbiter_if.sv
// Avalon-MM write-only master bundle between the MEMS write arbiter and the on-chip RAM slave.
interface mems_write_arbiter_if;
    logic [31:0] address;
    logic        write;
    logic [7:0]  write_data;
    logic        waitrequest;

    modport master (output address, write, write_data, input waitrequest);
    modport slave  (input address, write, write_data, output waitrequest);
endinterface

// File: rtl/mems_write_arbiter.sv
// Round-robin sharing of one Avalon-MM RAM write port among NUM_CH mic channels (one-shot mode: MEMS_ONESHOT_EN).
// Strobe to write request is 2 cycles; waitrequest holds the write, and a second strobe on a pending channel is dropped.
module mems_write_arbiter #(
    parameter int          NUM_CH    = 4,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 capture_en,
    input  logic [NUM_CH-1:0]    sample_valid,
    input  logic [8*NUM_CH-1:0]  sample_data,
    mems_write_arbiter_if.master mem,
    output logic [NUM_CH-1:0]    overflow,
    output logic [NUM_CH-1:0]    ch_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE, WRITE} state_t;
    state_t state, state_nxt;

    logic [NUM_CH-1:0] pending;
    logic [7:0]        hold [NUM_CH];
    logic [PW-1:0]     ptr  [NUM_CH];
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     cur;
    logic [NUM_CH-1:0] full_q;

    logic [NUM_CH-1:0] req;
    logic              grant_vld;
    logic [GW-1:0]     grant_idx;
    logic              done;
    int                idx;

    assign ch_full = full_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Full channels keep any stale pending bit but never compete for the port.
    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_idx = last_grant;
        idx       = 0;
        req       = pending & ~full_q;
        done      = (state == WRITE) && mem.write && !mem.waitrequest;
        if (state == IDLE) begin
            if (capture_en) begin
                for (int k = 1; k <= NUM_CH; k++) begin
                    idx = int'(last_grant) + k;
                    if (idx >= NUM_CH) idx = idx - NUM_CH;
                    if (!grant_vld && req[GW'(idx)]) begin
                        grant_vld = 1'b1;
                        grant_idx = GW'(idx);
                    end
                end
            end
            if (grant_vld) state_nxt = WRITE;
        end else if (done) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem.address    <= '0;
            mem.write      <= 1'b0;
            mem.write_data <= '0;
            pending        <= '0;
            overflow       <= '0;
            last_grant     <= GW'(NUM_CH - 1);
            cur            <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hold[i] <= '0;
                ptr[i]  <= '0;
            end
        end else begin
            if (grant_vld) begin
                mem.address    <= BASE_ADDR + (32'(grant_idx) << PW) + 32'(ptr[grant_idx]);
                mem.write      <= 1'b1;
                mem.write_data <= hold[grant_idx];
                last_grant     <= grant_idx;
                cur            <= grant_idx;
            end else if (done) begin
                mem.write <= 1'b0;
`ifdef MEMS_ONESHOT_EN
                if (ptr[cur] != PW'(DEPTH - 1)) ptr[cur] <= ptr[cur] + PW'(1);
`else
                ptr[cur] <= ptr[cur] + PW'(1);
`endif
            end

            // A strobe landing on the grant cycle refills the hold register that was just read out.
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant_vld && grant_idx == GW'(i)) pending[i] <= 1'b0;
                if (capture_en && sample_valid[i] && !full_q[i]) begin
                    if (!pending[i] || (grant_vld && grant_idx == GW'(i))) begin
                        hold[i]    <= sample_data[8*i +: 8];
                        pending[i] <= 1'b1;
                    end else begin
                        overflow[i] <= 1'b1;
                    end
                end
            end

            if (state == IDLE && !capture_en) begin
                pending  <= '0;
                overflow <= '0;
                for (int i = 0; i < NUM_CH; i++) ptr[i] <= '0;
            end
        end
    end

`ifdef MEMS_ONESHOT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                     full_q <= '0;
        else if (state == IDLE && !capture_en)         full_q <= '0;
        else if (done && ptr[cur] == PW'(DEPTH - 1))   full_q[cur] <= 1'b1;
    end
`else
    assign full_q = '0;
`endif
endmodule

// File: doc/mems_write_arbiter.md
# mems_write_arbiter

Round-robin write arbiter that shares the single Avalon-MM on-chip memory write port between NUM_CH decimated MEMS microphone channels. Each channel delivers 8-bit samples as single-cycle strobes; the block buffers one sample per channel and writes it into that channel's circular region of on-chip RAM. It also tracks per-channel write pointers and flags dropped samples. It sits between the per-microphone PDM decimators and the on-chip RAM slave.

## Interface
Parameters:
- NUM_CH, 4, number of microphone channels (1..8)
- DEPTH, 1024, samples per channel region; power of two
- BASE_ADDR, 32'd0, byte address of channel 0 region

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- capture_en  in  1  capture enable; low = idle and clear
- sample_valid  in  NUM_CH  one-cycle strobe per channel
- sample_data  in  8*NUM_CH  channel i sample on bits [8i+7:8i]
- address  out  32  Avalon write address (registered)
- write  out  1  Avalon write request (registered)
- write_data  out  8  Avalon write data (registered)
- waitrequest  in  1  Avalon slave stall
- overflow  out  NUM_CH  sticky; sample dropped on channel i
- ch_full  out  NUM_CH  channel region filled (see Configuration)

## Operation
- Per channel: pending bit, 8-bit hold register, pointer ptr[i] of log2(DEPTH) bits.
- Strobe capture, capture_en=1, ch_full[i]=0:
  - pending[i]=0: latch data and set pending.
  - pending[i]=1: drop the new sample, keep the old one, and set overflow[i].
  - Strobe in the same cycle the channel is granted: the new sample is latched, pending stays 1, and no overflow is flagged.
- The arbiter has two states, IDLE and WRITE.
- IDLE: if any pending bit is set, grant the first pending channel after last_grant, searching in ascending order with wrap.
  - Load address = BASE_ADDR + i*DEPTH + ptr[i], with i*DEPTH computed by shift.
  - Load write_data = hold[i] and set write=1.
  - Clear pending[i], set last_grant=i, go to WRITE.
- WRITE: hold address, write_data and write=1 while waitrequest=1.
  - When a cycle has write=1 and waitrequest=0, the transfer completes.
  - Next cycle: write=0, ptr[i] <= ptr[i]+1 mod DEPTH, return to IDLE.
- capture_en=0:
  - Strobes are ignored.
  - Any in-flight WRITE completes normally.
  - Once in IDLE, clear all pending bits, pointers, overflow and ch_full.
- Address arithmetic is 32-bit unsigned and never wraps outside the channel region.

## Timing
- Reset values: address=0, write=0, write_data=0, overflow=0, ch_full=0, all pointers and pending bits 0, state IDLE, last_grant=NUM_CH-1 (channel 0 wins first).
- Latency, strobe at cycle t with the arbiter idle: pending set at t+1, write=1 at t+2.
- Minimum write cadence is 2 cycles per sample: write cycle plus one idle cycle.
- Worst-case service interval for a channel with waitrequest=0 is 2*NUM_CH cycles.
- Reset asserted mid-write drops write to 0 immediately, with no completion or pointer update.

## Configuration
- MEMS_ONESHOT_EN defined: one-shot capture.
  - After DEPTH completed writes, ch_full[i]=1 and ptr[i] holds at DEPTH-1.
  - Further strobes on that channel are ignored and do not set overflow.
  - ch_full clears only on reset or capture_en=0.
- MEMS_ONESHOT_EN undefined: pointers wrap to 0 after DEPTH-1, ch_full is tied to 0, and capture runs continuously.

## Test plan
- Single write: ch0 strobe with 0x5A, waitrequest=0. Expect one write cycle at address BASE_ADDR with data 0x5A two cycles after the strobe, then ptr[0]=1.
- Round-robin: ch0..ch3 strobe in the same cycle with 0x11/0x22/0x33/0x44. Expect writes in order to addresses 0, 1024, 2048, 3072, spaced 2 cycles apart.
- Stall: waitrequest=1 for 5 cycles during a ch2 write. Expect address, data and write stable for 6 cycles, then write=0 and ptr[2] incremented exactly once.
- Overflow: ch1 strobes 0xAA then 0xBB while ch1 is pending behind a stall. Expect 0xAA written, 0xBB dropped, overflow[1]=1 sticky until capture_en=0.
- Wrap/one-shot, DEPTH=4, 5 strobes on ch0:
  - Macro off: addresses 0,1,2,3,0.
  - Macro on: addresses 0..3, then ch_full[0]=1, 5th strobe ignored, overflow[0]=0.
- Reset mid-write with waitrequest=1: expect write=0 asynchronously and all outputs at reset values.
